// File: rtl/game_frame_scheduler.sv
// Frame-synchronous game-state sequencer: once per frame (start of vertical blanking) it
// moves the player, advances the bullet pool, fires, then commits all sprite state at once.
module game_frame_scheduler #(
   parameter int SCREEN_W      = 640,
   parameter int SCREEN_H      = 480,
   parameter int PLAYER_SIZE   = 32,
   parameter int PLAYER_STEP   = 4,
   parameter int BULLET_STEP   = 8,
   parameter int FIRE_COOLDOWN = 8,
   parameter int START_X       = 304,
   parameter int START_Y       = 400
) (
   input  logic        Master_Clock_In,
   input  logic        Reset_In,
   input  logic        Up,
   input  logic        Down,
   input  logic        Left,
   input  logic        Right,
   input  logic        Fire,
   input  logic [9:0]  Val_Col_In,
   input  logic [9:0]  Val_Row_In,
   output logic [9:0]  Player_X_Out,
   output logic [9:0]  Player_Y_Out,
   output logic [3:0]  Bullet_Valid_Out,
   output logic [39:0] Bullet_X_Out,
   output logic [39:0] Bullet_Y_Out,
   output logic        Update_Busy_Out,
   output logic [15:0] Frame_Count_Out,
   output logic [2:0]  Sched_State_Out
);

   // Handshake: none. The frame tick is a level condition sampled only in IDLE;
   // a tick seen while busy is dropped, never queued.

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SAMPLE = 3'd1;
   localparam logic [2:0] S_MOVE   = 3'd2;
   localparam logic [2:0] S_BULLET = 3'd3;
   localparam logic [2:0] S_FIRE   = 3'd4;
   localparam logic [2:0] S_COMMIT = 3'd5;

   localparam logic signed [10:0] STEP_S  = 11'(PLAYER_STEP);
   localparam logic signed [10:0] MAX_X_S = 11'(SCREEN_W - PLAYER_SIZE);
   localparam logic signed [10:0] MAX_Y_S = 11'(SCREEN_H - PLAYER_SIZE);
   localparam logic [9:0]  B_STEP   = 10'(BULLET_STEP);
   localparam logic [9:0]  HALF_P   = 10'(PLAYER_SIZE / 2);
   localparam logic [7:0]  COOL_MAX = 8'(FIRE_COOLDOWN);

   logic [2:0]       state, state_next;
   logic [1:0]       slot_cnt;
   logic [4:0]       btn_meta, btn_sync, btn_lat;   // {up, down, left, right, fire}
   logic [7:0]       cooldown;

   logic [9:0]       sh_px, sh_py;
   logic [3:0]       sh_valid;
   logic [3:0][9:0]  sh_bx, sh_by;
   logic [3:0][9:0]  com_bx, com_by;

   logic             tick;
   logic signed [10:0] nx, ny;
   logic [9:0]       move_x, move_y;
   logic [1:0]       free_idx;
   logic             any_free;
   logic             shot;

   assign tick            = (Val_Row_In == 10'(SCREEN_H)) && (Val_Col_In == 10'd0);
   assign Bullet_X_Out    = com_bx;
   assign Bullet_Y_Out    = com_by;
   assign Sched_State_Out = state;

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (tick) state_next = S_SAMPLE;
         S_SAMPLE: state_next = S_MOVE;
         S_MOVE:   state_next = S_BULLET;
         S_BULLET: if (slot_cnt == 2'd3) state_next = S_FIRE;
         S_FIRE:   state_next = S_COMMIT;
         S_COMMIT: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Opposing directions cancel; results clamp to the visible area, never wrap.
   always_comb begin
      nx = $signed({1'b0, sh_px});
      ny = $signed({1'b0, sh_py});
      if (btn_lat[4] && !btn_lat[3]) ny = ny - STEP_S;
      if (btn_lat[3] && !btn_lat[4]) ny = ny + STEP_S;
      if (btn_lat[2] && !btn_lat[1]) nx = nx - STEP_S;
      if (btn_lat[1] && !btn_lat[2]) nx = nx + STEP_S;
      if (nx < 11'sd0)        move_x = 10'd0;
      else if (nx > MAX_X_S)  move_x = MAX_X_S[9:0];
      else                    move_x = nx[9:0];
      if (ny < 11'sd0)        move_y = 10'd0;
      else if (ny > MAX_Y_S)  move_y = MAX_Y_S[9:0];
      else                    move_y = ny[9:0];
   end

   // Lowest-index free slot; slots cleared in this frame's bullet phase count as free.
   always_comb begin
      free_idx = 2'd0;
      any_free = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (!sh_valid[i]) begin
            free_idx = 2'(i);
            any_free = 1'b1;
         end
      end
   end

   assign shot = btn_lat[0] && (cooldown == 8'd0) && any_free;

   always_ff @(posedge Master_Clock_In) begin
      if (Reset_In) begin
         state            <= S_IDLE;
         slot_cnt         <= 2'd0;
         btn_meta         <= '0;
         btn_sync         <= '0;
         btn_lat          <= '0;
         cooldown         <= 8'd0;
         sh_px            <= 10'(START_X);
         sh_py            <= 10'(START_Y);
         sh_valid         <= '0;
         sh_bx            <= '0;
         sh_by            <= '0;
         Player_X_Out     <= 10'(START_X);
         Player_Y_Out     <= 10'(START_Y);
         Bullet_Valid_Out <= '0;
         com_bx           <= '0;
         com_by           <= '0;
         Update_Busy_Out  <= 1'b0;
         Frame_Count_Out  <= 16'd0;
      end else begin
         btn_meta        <= {Up, Down, Left, Right, Fire};
         btn_sync        <= btn_meta;
         state           <= state_next;
         Update_Busy_Out <= (state_next != S_IDLE);
         case (state)
            S_SAMPLE: begin
               btn_lat  <= btn_sync;
               sh_px    <= Player_X_Out;
               sh_py    <= Player_Y_Out;
               sh_valid <= Bullet_Valid_Out;
               sh_bx    <= com_bx;
               sh_by    <= com_by;
               slot_cnt <= 2'd0;
            end
            S_MOVE: begin
               sh_px <= move_x;
               sh_py <= move_y;
            end
            S_BULLET: begin
               if (sh_valid[slot_cnt]) begin
                  if (sh_by[slot_cnt] >= B_STEP) sh_by[slot_cnt] <= sh_by[slot_cnt] - B_STEP;
                  else                           sh_valid[slot_cnt] <= 1'b0;
               end
               slot_cnt <= slot_cnt + 2'd1;
            end
            S_FIRE: begin
               if (shot) begin
                  sh_valid[free_idx] <= 1'b1;
                  sh_bx[free_idx]    <= sh_px + HALF_P;
                  sh_by[free_idx]    <= sh_py;
                  cooldown           <= COOL_MAX;
               end else if (cooldown != 8'd0) begin
                  cooldown <= cooldown - 8'd1;
               end
            end
            S_COMMIT: begin
               Player_X_Out     <= sh_px;
               Player_Y_Out     <= sh_py;
               Bullet_Valid_Out <= sh_valid;
               com_bx           <= sh_bx;
               com_by           <= sh_by;
               Frame_Count_Out  <= Frame_Count_Out + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
